// File: rtl/fetch_decode_buffer.sv
// Fetch-to-decode skid FIFO: DEPTH entries of the 132-bit fetch payload, with flush and async reset.
// Optional same-cycle bypass when empty is enabled by defining FD_BUF_BYPASS_EN.
module fetch_decode_buffer #(
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [63:0]              pc_i,
  input  logic [6:0]               opcode_i,
  input  logic [4:0]               rd_i,
  input  logic [9:0]               funct_i,
  input  logic [4:0]               rs1_i,
  input  logic [4:0]               rs2_i,
  input  logic [31:0]              imm_i,
  input  logic [2:0]               instr_type_i,
  input  logic                     imem_error_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [63:0]              pc_o,
  output logic [6:0]               opcode_o,
  output logic [4:0]               rd_o,
  output logic [9:0]               funct_o,
  output logic [4:0]               rs1_o,
  output logic [4:0]               rs2_o,
  output logic [31:0]              imm_o,
  output logic [2:0]               instr_type_o,
  output logic                     imem_error_o,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [63:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [9:0]  funct;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [2:0]  instr_type;
    logic        imem_error;
  } fd_pkt_t;

  fd_pkt_t          mem_q [DEPTH];
  fd_pkt_t          mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  fd_pkt_t          in_pkt, out_pkt;
  logic             full, empty, byp, push, pop;

  always_comb begin
    in_pkt      = '{pc: pc_i, opcode: opcode_i, rd: rd_i, funct: funct_i, rs1: rs1_i,
                    rs2: rs2_i, imm: imm_i, instr_type: instr_type_i, imem_error: imem_error_i};
    full        = (count_q == CW'(DEPTH));
    empty       = (count_q == '0);
    in_ready_o  = ~full & ~flush_i;
`ifdef FD_BUF_BYPASS_EN
    byp         = empty & in_valid_i & ~flush_i;
`else
    byp         = 1'b0;
`endif
    out_valid_o = (~empty & ~flush_i) | byp;
    if (!out_valid_o)  out_pkt = '0;
    else if (byp)      out_pkt = in_pkt;
    else               out_pkt = mem_q[rd_ptr_q];
    // A bypassed entry consumed the same cycle never touches storage.
    push        = in_valid_i & in_ready_o & ~(byp & out_ready_i);
    pop         = out_valid_o & out_ready_i & ~empty;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_pkt;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign pc_o         = out_pkt.pc;
  assign opcode_o     = out_pkt.opcode;
  assign rd_o         = out_pkt.rd;
  assign funct_o      = out_pkt.funct;
  assign rs1_o        = out_pkt.rs1;
  assign rs2_o        = out_pkt.rs2;
  assign imm_o        = out_pkt.imm;
  assign instr_type_o = out_pkt.instr_type;
  assign imem_error_o = out_pkt.imem_error;
  assign count_o      = count_q;

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Randomized + directed bench for fetch_decode_buffer; a queue model tracks expected contents.
module tb_fetch_decode_buffer;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, flush = 0;
  logic [63:0] pc_i = 0, pc_o;
  logic [6:0]  opc_i = 0, opc_o;
  logic [4:0]  rd_i = 0, rd_o, rs1_i = 0, rs1_o, rs2_i = 0, rs2_o;
  logic [9:0]  fn_i = 0, fn_o;
  logic [31:0] imm_i = 0, imm_o;
  logic [2:0]  ty_i = 0, ty_o;
  logic        er_i = 0, er_o;
  logic [CW-1:0] count;

  int checks = 0, errors = 0;
  logic [131:0] q[$];
  logic pop_pend = 0;

  always #5 clk = ~clk;

  fetch_decode_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .pc_i(pc_i), .opcode_i(opc_i), .rd_i(rd_i), .funct_i(fn_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .imm_i(imm_i), .instr_type_i(ty_i), .imem_error_i(er_i),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .pc_o(pc_o), .opcode_o(opc_o), .rd_o(rd_o), .funct_o(fn_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .imm_o(imm_o), .instr_type_o(ty_o), .imem_error_o(er_o),
    .flush_i(flush), .count_o(count));

  function automatic logic [131:0] in_pay();
    return {pc_i, opc_i, rd_i, fn_i, rs1_i, rs2_i, imm_i, ty_i, er_i};
  endfunction

  task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected handshake view derived from the model queue and current inputs.
  function automatic logic exp_byp();
`ifdef FD_BUF_BYPASS_EN
    return (q.size() == 0) && in_valid && !flush;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_ovld();
    return ((q.size() != 0) && !flush) || exp_byp();
  endfunction

  // Monitor: compares outputs mid-cycle and records a pop for the model.
  always @(negedge clk) begin
    logic [131:0] ep;
    ep = !exp_ovld() ? 132'd0 : (exp_byp() ? in_pay() : q[0]);
    chk("in_ready",  {131'd0, in_ready},  {131'd0, (q.size() != DEPTH) && !flush});
    chk("out_valid", {131'd0, out_valid}, {131'd0, exp_ovld()});
    chk("count",     {{(132-CW){1'b0}}, count}, 132'(q.size()));
    chk("payload",   {pc_o, opc_o, rd_o, fn_o, rs1_o, rs2_o, imm_o, ty_o, er_o}, ep);
    pop_pend = exp_ovld() && out_ready && !exp_byp();
  end

  // Model update on the clock edge, using state from before the edge.
  always @(posedge clk) begin
    if (rst_n) begin
      logic accept;
      accept = in_valid && (q.size() != DEPTH) && !flush && !(exp_byp() && out_ready);
      if (flush) q.delete();
      else begin
        if (pop_pend) void'(q.pop_front());
        if (accept) q.push_back(in_pay());
      end
    end
    pop_pend = 0;
  end

  always @(negedge rst_n) begin
    q.delete();
    pop_pend = 0;
  end

  task automatic step(input logic iv, input logic [63:0] pc, input logic [31:0] imm,
                      input logic er, input logic ordy, input logic fl);
    @(posedge clk); #1;
    in_valid = iv; pc_i = pc; imm_i = imm; er_i = er; out_ready = ordy; flush = fl;
    opc_i = 7'($urandom); rd_i = 5'($urandom); fn_i = 10'($urandom);
    rs1_i = 5'($urandom); rs2_i = 5'($urandom); ty_i = 3'($urandom);
  endtask

  task automatic mid_reset();
    @(posedge clk); #3;
    rst_n = 0; in_valid = 0; flush = 0;
    #1;
    chk("rst_out_valid", {131'd0, out_valid}, 132'd0);
    chk("rst_count", {{(132-CW){1'b0}}, count}, 132'd0);
    chk("rst_pc", {68'd0, pc_o}, 132'd0);
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    step(1, 64'h1000, 32'h10, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    // fill to full, third entry held until space appears, then drain
    step(1, 64'h0, 1, 0, 0, 0);
    step(1, 64'h4, 2, 0, 0, 0);
    step(1, 64'h8, 3, 0, 0, 0);
    step(1, 64'h8, 3, 0, 0, 0);
    step(1, 64'h8, 3, 0, 1, 0);
    step(1, 64'h8, 3, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    // steady state push+pop at count 1, pointers wrap
    step(1, 64'h0, 0, 0, 0, 0);
    for (int i = 1; i <= 6; i++) step(1, 64'(i * 4), 32'(i), 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    // flush with full buffer and incoming entry
    step(1, 64'h100, 0, 0, 0, 0);
    step(1, 64'h104, 0, 0, 0, 0);
    step(1, 64'h108, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    // erroneous fetch is carried through, then reset mid-stream
    step(1, 64'hDEAD0, 32'h77, 1, 0, 0);
    step(1, 64'hDEAD4, 32'h78, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 64'h300, 0, 0, 0, 0);
    mid_reset();
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) mid_reset();
      else step($urandom_range(0, 2) != 0, {$urandom, $urandom}, $urandom, 1'($urandom),
                $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end
    step(0, 0, 0, 0, 1, 0);
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
